// File: rtl/sync_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg
// Shared helpers for the clock-domain-crossing blocks.
//   MAX_W     : widest crossing value the helpers handle (32 bits)
//   MULTI     : SDC statement relaxing setup into the first capture flop
//   FHOLD     : SDC statement cutting hold checks into the first capture flop
//   gray2bin  : gray-to-binary decode; narrower values are zero-extended by
//               the caller, which leaves the low bits of the result unchanged
//   popcount  : number of set bits in a value
// -----------------------------------------------------------------------------
package sync_pkg;

    localparam int MAX_W = 32;

    localparam string MULTI =
        "-name SDC_STATEMENT \"set_multicycle_path 2 -to [get_keepers *sync_gray_rx*sync0*]\"";
    localparam string FHOLD =
        "-name SDC_STATEMENT \"set_false_path -hold -to [get_keepers *sync_gray_rx*sync0*]\"";

    // Each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MAX_W; i++) begin
            cnt = cnt + 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Bitwise flop chain bringing an asynchronous bus into the dout_clk domain.
//   dout_clk : destination clock
//   aclr     : asynchronous active-high clear of every stage
//   din      : WIDTH-bit value launched from a foreign-domain register
//   q        : value after STAGES flops
// The first stage (sync0) is the metastable capture flop and carries the SDC
// relaxations; every stage is kept intact through synthesis so the chain is
// never merged, retimed or duplicated.
// -----------------------------------------------------------------------------
module sync_chain
    import sync_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             dout_clk,
    input  logic             aclr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    (* preserve, dont_replicate, altera_attribute = {MULTI, ";", FHOLD, ";", "-name POWER_UP_LEVEL LOW"} *)
    logic [WIDTH-1:0] sync0;

    (* preserve, dont_replicate, altera_attribute = "-name POWER_UP_LEVEL LOW" *)
    logic [WIDTH-1:0] sync_tail [STAGES-1];

    // NOTE: the chain is a handful of real flops, not a RAM, so every element is
    // cleared by aclr; a stale value here would surface as a bogus first sample.
    always_ff @(posedge dout_clk or posedge aclr) begin
        if (aclr) begin
            sync0 <= '0;
            for (int k = 0; k < STAGES - 1; k++) begin
                sync_tail[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample the value its
            // predecessor held before this edge, giving a true shift register.
            sync0        <= din;
            sync_tail[0] <= sync0;
            for (int k = 1; k < STAGES - 1; k++) begin
                sync_tail[k] <= sync_tail[k-1];
            end
        end
    end

    assign q = sync_tail[STAGES-2];

endmodule

// File: rtl/sync_gray_rx.sv
// -----------------------------------------------------------------------------
// sync_gray_rx
// Receive-side synchronizer for gray-coded counters from a foreign clock.
//   dout_clk : destination clock
//   aclr     : asynchronous active-high clear of every flop
//   din      : WIDTH-bit value (gray if GRAY=1) from a source-domain register
//   err_clr  : synchronous clear of err; a same-edge set takes priority
//   dout     : synchronized value, binary when GRAY=1, raw when GRAY=0
//   delta    : (dout - previous dout) mod 2^WIDTH
//   changed  : one-cycle pulse when dout takes a new value
//   valid    : low while the chain still holds post-reset samples
//   err      : sticky; a synced gray sample moved by more than one bit
// All outputs are registered; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module sync_gray_rx
    import sync_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter bit GRAY   = 1'b1
) (
    input  logic             dout_clk,
    input  logic             aclr,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] delta,
    output logic             changed,
    output logic             valid,
    output logic             err
);

    localparam int CNT_MAX = STAGES + 1;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] bin;
    logic             multi_bit;
    logic [CW-1:0]    warm_cnt;

    sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_chain (
        .dout_clk (dout_clk),
        .aclr     (aclr),
        .din      (din),
        .q        (sync_q)
    );

    // NOTE: defaults first means every path assigns every output, so no latch
    // is inferred even though GRAY=0 skips the decode branch.
    always_comb begin
        bin       = sync_q;
        multi_bit = 1'b0;
        if (GRAY) begin
            bin       = WIDTH'(gray2bin(MAX_W'(sync_q)));
            multi_bit = popcount(MAX_W'(sync_q ^ prev_gray)) > 1;
        end
    end

    // The counter saturates at STAGES+1: by then every flop of the chain plus
    // prev_gray has been loaded from din, so comparisons are meaningful.
    assign valid = (warm_cnt == CW'(CNT_MAX));

    always_ff @(posedge dout_clk or posedge aclr) begin
        if (aclr) begin
            warm_cnt  <= '0;
            prev_gray <= '0;
            dout      <= '0;
            delta     <= '0;
            changed   <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (!valid) begin
                warm_cnt <= warm_cnt + CW'(1);
            end
            prev_gray <= sync_q;
            dout      <= bin;
            delta     <= bin - dout;
            changed   <= (bin != dout);
            // Jumps seen during warm-up (e.g. nonzero din at release) are ignored.
            if (GRAY && valid && multi_bit) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_gray_rx.sv
// -----------------------------------------------------------------------------
// tb_sync_gray_rx
// Two instances share clock, aclr and err_clr: u_g (GRAY=1, STAGES=2) and
// u_r (GRAY=0, STAGES=3). A reference model records the din value seen at
// each edge since reset release; expected outputs follow directly from that
// history: dout after edge n is the decoded sample taken at edge n-STAGES.
// -----------------------------------------------------------------------------
module tb_sync_gray_rx;

    localparam int SG = 2;
    localparam int SR = 3;

    logic       dout_clk = 1'b0;
    logic       aclr     = 1'b1;
    logic       err_clr  = 1'b0;
    logic [7:0] din_g    = 8'h00;
    logic [7:0] din_r    = 8'h00;

    logic [7:0] dout_g, delta_g, dout_r, delta_r;
    logic       changed_g, valid_g, err_g;
    logic       changed_r, valid_r, err_r;

    sync_gray_rx #(.WIDTH(8), .STAGES(SG), .GRAY(1'b1)) u_g (
        .dout_clk (dout_clk),
        .aclr     (aclr),
        .din      (din_g),
        .err_clr  (err_clr),
        .dout     (dout_g),
        .delta    (delta_g),
        .changed  (changed_g),
        .valid    (valid_g),
        .err      (err_g)
    );

    sync_gray_rx #(.WIDTH(8), .STAGES(SR), .GRAY(1'b0)) u_r (
        .dout_clk (dout_clk),
        .aclr     (aclr),
        .din      (din_r),
        .err_clr  (err_clr),
        .dout     (dout_r),
        .delta    (delta_r),
        .changed  (changed_r),
        .valid    (valid_r),
        .err      (err_r)
    );

    always #5 dout_clk = ~dout_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] gray_dec [256];
    logic [7:0] q_g [$];
    logic [7:0] q_r [$];
    int         n = 0;
    logic       m_err_g = 1'b0;

    typedef struct {
        logic [7:0] din;
        logic       clr;
        logic [7:0] dout;
        logic [7:0] delta;
        logic       changed;
        logic       err;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gray(input int i);
        return 8'(i ^ (i >> 1));
    endfunction

    // din sampled at edge k (k counted from 1 after reset release); 0 before.
    function automatic logic [7:0] hist(input bit raw, input int k);
        if (k < 1) return 8'h00;
        return raw ? q_r[k-1] : q_g[k-1];
    endfunction

    task automatic tick();
        logic [7:0] eg, eg_prev, dg, er, er_prev, dr;
        @(posedge dout_clk);
        if (!aclr) begin
            n++;
            q_g.push_back(din_g);
            q_r.push_back(din_r);
            if ((n - 1 >= SG + 1) && ($countones(hist(1'b0, n - SG) ^ hist(1'b0, n - SG - 1)) > 1))
                m_err_g = 1'b1;
            else if (err_clr)
                m_err_g = 1'b0;
        end
        #1;
        eg      = gray_dec[hist(1'b0, n - SG)];
        eg_prev = gray_dec[hist(1'b0, n - SG - 1)];
        dg      = eg - eg_prev;
        er      = hist(1'b1, n - SR);
        er_prev = hist(1'b1, n - SR - 1);
        dr      = er - er_prev;
        check("g_dout",    dout_g,    eg);
        check("g_delta",   delta_g,   dg);
        check("g_changed", changed_g, eg != eg_prev);
        check("g_valid",   valid_g,   n >= SG + 1);
        check("g_err",     err_g,     m_err_g);
        check("r_dout",    dout_r,    er);
        check("r_delta",   delta_r,   dr);
        check("r_changed", changed_r, er != er_prev);
        check("r_valid",   valid_r,   n >= SR + 1);
        check("r_err",     err_r,     1'b0);
    endtask

    // Asserts aclr between edges, checks the asynchronous clear, holds it for
    // two edges and releases it just after an edge.
    task automatic do_reset();
        #2 aclr = 1'b1;
        #1;
        check("rst_dout_g",  dout_g,  8'h00);
        check("rst_delta_g", delta_g, 8'h00);
        check("rst_chg_g",   changed_g, 1'b0);
        check("rst_valid_g", valid_g, 1'b0);
        check("rst_err_g",   err_g,   1'b0);
        check("rst_dout_r",  dout_r,  8'h00);
        check("rst_valid_r", valid_r, 1'b0);
        n = 0;
        q_g.delete();
        q_r.delete();
        m_err_g = 1'b0;
        tick();
        tick();
        aclr = 1'b0;
    endtask

    initial begin
        int chg;
        int bad;
        int gidx;
        int r;

        for (int i = 0; i < 256; i++) gray_dec[gray(i)] = 8'(i);

        //           din    clr   dout   delta  chg   err
        tbl[0]  = '{8'h04, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{8'h04, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{8'h04, 1'b0, 8'h07, 8'h02, 1'b1, 1'b1};
        tbl[3]  = '{8'h04, 1'b1, 8'h07, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{8'h05, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{8'h05, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{8'h05, 1'b0, 8'h06, 8'hFF, 1'b1, 1'b0};
        tbl[7]  = '{8'h02, 1'b0, 8'h06, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{8'h02, 1'b0, 8'h06, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{8'h02, 1'b1, 8'h03, 8'hFD, 1'b1, 1'b1};
        tbl[10] = '{8'h02, 1'b1, 8'h03, 8'h00, 1'b0, 1'b0};

        // Reset release with din = 0: valid on 3rd edge (STAGES=2), 4th (STAGES=3)
        do_reset();
        tick();
        tick();
        check("warm_g_edge2", valid_g, 1'b0);
        tick();
        check("warm_g_edge3", valid_g, 1'b1);
        check("warm_r_edge3", valid_r, 1'b0);
        tick();
        check("warm_r_edge4", valid_r, 1'b1);
        check("warm_g_err",   err_g,   1'b0);

        // Nonzero din through reset release is absorbed, then table vectors
        din_g = gray(5);
        do_reset();
        repeat (5) tick();
        check("absorb_dout", dout_g, 8'h05);
        check("absorb_err",  err_g,  1'b0);
        for (int v = 0; v < 11; v++) begin
            din_g   = tbl[v].din;
            err_clr = tbl[v].clr;
            tick();
            check("tbl_dout",    dout_g,    tbl[v].dout);
            check("tbl_delta",   delta_g,   tbl[v].delta);
            check("tbl_changed", changed_g, tbl[v].changed);
            check("tbl_err",     err_g,     tbl[v].err);
        end
        err_clr = 1'b0;

        // Full gray count with wrap, one step per 3 cycles
        din_g = 8'h00;
        do_reset();
        repeat (4) tick();
        chg = 0;
        bad = 0;
        for (int i = 1; i <= 256; i++) begin
            din_g = gray(i % 256);
            repeat (3) begin
                tick();
                if (changed_g) begin
                    chg++;
                    if (delta_g != 8'h01) bad++;
                end
            end
        end
        check("count_changes",   chg,    256);
        check("count_bad_delta", bad,    0);
        check("count_wrap_dout", dout_g, 8'h00);
        check("count_err",       err_g,  1'b0);

        // aclr mid-count at dout = 0x40
        for (int i = 1; i <= 8'h40; i++) begin
            din_g = gray(i);
            repeat (3) tick();
        end
        check("pre_aclr_dout", dout_g, 8'h40);
        do_reset();
        tick();
        check("aclr_valid_e1", valid_g, 1'b0);
        tick();
        check("aclr_valid_e2", valid_g, 1'b0);
        tick();
        check("aclr_valid_e3", valid_g, 1'b1);
        check("aclr_dout",     dout_g,  8'h40);
        repeat (3) tick();
        check("aclr_no_err",   err_g,   1'b0);

        // Raw mode: 0xA5 then 0x5A through STAGES=3
        din_r = 8'hA5;
        repeat (4) tick();
        check("raw_a5_dout", dout_r, 8'hA5);
        din_r = 8'h5A;
        repeat (3) tick();
        check("raw_hold_dout", dout_r, 8'hA5);
        tick();
        check("raw_5a_dout",  dout_r,    8'h5A);
        check("raw_5a_delta", delta_r,   8'hB5);
        check("raw_5a_chg",   changed_r, 1'b1);
        check("raw_err",      err_r,     1'b0);

        // Random: 0..2 gray steps per sample, random err_clr, rare aclr
        gidx = 8'h40;
        for (int t = 0; t < 2000; t++) begin
            r = int'($urandom_range(0, 9));
            gidx += (r < 6) ? 0 : (r < 8) ? 1 : 2;
            din_g   = gray(gidx % 256);
            din_r   = 8'($urandom);
            err_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
